mem_slice: RTL and testbench
============================

// Module: mem_slice
// PURPOSE
//   MEM stage of the 5-stage pipeline; consumes the EX stage outputs (addr, data, result, WB, M).
//   Registers them, performs data-memory loads/stores over a req/ack handshake, and posts stores
//   through a one-entry write buffer. Produces the write-back value and the pipeline stall.
// PARAMETERS
//   DW          16   data/address width
//   TIMEOUT_CYC 255  cycles dmem_req may stay high without dmem_ack before abort (>=1)
// PORTS
//   clk         in   1    clock, all state on rising edge
//   rst         in   1    reset, synchronous, active-high
//   WB_in       in   7    write-back control from EX, passed through untouched
//   M_in        in   3    mem control: [0] MemRead, [1] MemWrite, [2] MemToReg
//   addr_in     in   DW   effective address from EX
//   data_in     in   DW   store data from EX
//   result_in   in   DW   ALU result from EX
//   dmem_req    out  1    memory request valid
//   dmem_we     out  1    1 = write, 0 = read (valid with dmem_req)
//   dmem_addr   out  DW   request address
//   dmem_wdata  out  DW   request write data
//   dmem_ack    in   1    request complete this cycle; read data valid this cycle
//   dmem_rdata  in   DW   read data
//   WB          out  7    registered WB_in
//   wb_data     out  DW   MemToReg ? load data : registered result
//   mem_stall   out  1    hold IF..EX and this stage's input register
//   wbuf_empty  out  1    write buffer empty (halt logic waits on it)
//   bus_err     out  1    one-cycle pulse on request timeout
// BEHAVIOUR
//   Reset (synchronous): all input regs 0, write buffer invalid, state IDLE, timeout count 0.
//     Resulting outputs: WB=0, wb_data=0, dmem_req=0, dmem_we=0, mem_stall=0,
//     wbuf_empty=1, bus_err=0. Reset wins over any in-flight handshake; the request is dropped.
//   Input register loads on every edge where mem_stall=0; holds otherwise.
//   MemRead and MemWrite both set: treated as store.
//   Write buffer (wbuf_valid, wbuf_addr, wbuf_data):
//     - A store in the register is accepted when the buffer is empty, or when it is draining and
//       dmem_ack=1 this cycle. It is captured at the edge and the pipeline does not stall.
//       Otherwise mem_stall=1.
//     - While wbuf_valid: dmem_req=1, dmem_we=1, addr/wdata from the buffer. Cleared on ack.
//   Loads:
//     - Buffer valid and wbuf_addr==addr: wb_data=wbuf_data, no memory access, no stall.
//     - Buffer valid, address differs: stall; drain has port priority. Read issues the cycle
//       after the drain ack.
//     - Buffer empty: dmem_req=1, dmem_we=0, addr=addr_r; mem_stall=1 until dmem_ack.
//       In the ack cycle mem_stall=0 and wb_data=dmem_rdata (zero-wait ack is legal).
//   Non-memory op: wb_data=result_r, no stall unless a buffered store blocks nothing
//     (non-mem ops never stall).
//   dmem_addr/dmem_we/dmem_wdata stay stable while dmem_req=1 and dmem_ack=0.
//   FSM states:
//     IDLE  -> DRAIN on store capture; IDLE -> READ on a load miss with empty buffer.
//     DRAIN -> IDLE on ack; DRAIN -> DRAIN on ack with a new store accepted.
//     READ  -> IDLE on ack.
//   Timeout: counter increments while dmem_req && !dmem_ack and clears otherwise. On reaching
//     TIMEOUT_CYC the stage acts as if acked, with read data forced to 16'h0000, and bus_err=1
//     for that cycle.
// STRUCTURE
//   cpu_pkg:
//     - M bit indices: M_RD=0, M_WR=1, M_TOREG=2
//     - typedef enum logic [1:0] {IDLE, DRAIN, READ} mem_state_t
//   Sub-module mem_wbuf: one-entry buffer holding valid/addr/data, with a load/clear interface
//     and an addr-match output. Everything else stays in mem_slice.
// TESTING
//   1 Load, buffer empty, ack after 3 cycles, rdata=16'hBEEF, M=3'b101
//     -> mem_stall high 3 cycles, wb_data=16'hBEEF in ack cycle.
//   2 Store addr 16'h0040 data 16'h1234, ack after 2 cycles
//     -> no stall; 2 cycles of dmem_req/we=1 with stable addr/data; wbuf_empty=1 after ack.
//   3 Store 0x0040=0x1234 then immediately load 0x0040
//     -> wb_data=16'h1234, no stall, no read request.
//   4 Store 0x0040 then load 0x0050
//     -> stall; write drains first, then read 0x0050; no overlap of requests.
//   5 Back-to-back stores, ack held low 2 cycles
//     -> second store stalls until first ack, then enters the buffer on the same edge.
//   6 dmem_ack never asserted, TIMEOUT_CYC=4
//     -> bus_err pulse after 4 req cycles, wb_data=0, stall released; rst mid-READ
//     -> dmem_req=0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the CPU core.
// Control-field layouts and MEM stage state encoding.
package cpu_pkg;

  localparam int WB_W    = 7;
  localparam int M_W     = 3;

  localparam int M_RD    = 0;
  localparam int M_WR    = 1;
  localparam int M_TOREG = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_slice_wbuf.sv
// One-entry posted-store buffer for the MEM stage.
// Load wins over clear so a new store can replace a draining one.
module mem_wbuf #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] addr_in,
  input  logic [DW-1:0] data_in,
  input  logic [DW-1:0] cmp_addr,
  output logic          valid,
  output logic [DW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          hit
);

  // entry storage: capture on load, invalidate on clear
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= addr_in;
      data  <= data_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid & (addr == cmp_addr);

endmodule

// File: rtl/mem_slice.sv
// MEM pipeline stage: input register, load/store over req/ack,
// posted stores via a one-entry buffer, request timeout.
module mem_slice
  import cpu_pkg::*;
#(
  parameter int DW          = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WB_W-1:0] WB_in,
  input  logic [M_W-1:0]  M_in,
  input  logic [DW-1:0]   addr_in,
  input  logic [DW-1:0]   data_in,
  input  logic [DW-1:0]   result_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [DW-1:0]   dmem_addr,
  output logic [DW-1:0]   dmem_wdata,
  input  logic            dmem_ack,
  input  logic [DW-1:0]   dmem_rdata,
  output logic [WB_W-1:0] WB,
  output logic [DW-1:0]   wb_data,
  output logic            mem_stall,
  output logic            wbuf_empty,
  output logic            bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [WB_W-1:0] wb_r;
  logic [M_W-1:0]  m_r;
  logic [DW-1:0]   addr_r;
  logic [DW-1:0]   data_r;
  logic [DW-1:0]   result_r;

  mem_state_t state, state_n;
  logic [CW-1:0] tmo_cnt;

  logic          is_ld, is_st, to_reg;
  logic          wbuf_valid, wbuf_hit;
  logic [DW-1:0] wbuf_addr, wbuf_data;
  logic          ld_hit, rd_req, req_c;
  logic          tmo, ack_eff, st_acc, wbuf_clr;

  assign is_st  = m_r[M_WR];
  assign is_ld  = m_r[M_RD] & ~m_r[M_WR];
  assign to_reg = m_r[M_TOREG];

  assign ld_hit = is_ld & wbuf_hit;
  assign rd_req = is_ld & ~wbuf_valid;
  assign req_c  = (state != IDLE) | rd_req;

  // a timed-out request completes like an ack
  assign tmo     = req_c & ~dmem_ack
                 & (tmo_cnt == CW'(TIMEOUT_CYC));
  assign ack_eff = req_c & (dmem_ack | tmo);

  assign st_acc   = is_st & (~wbuf_valid | ack_eff);
  assign wbuf_clr = (state == DRAIN) & ack_eff;

  mem_wbuf #(.DW(DW)) u_wbuf (
    .clk      (clk),
    .rst      (rst),
    .load     (st_acc),
    .clear    (wbuf_clr),
    .addr_in  (addr_r),
    .data_in  (data_r),
    .cmp_addr (addr_r),
    .valid    (wbuf_valid),
    .addr     (wbuf_addr),
    .data     (wbuf_data),
    .hit      (wbuf_hit)
  );

  // stage input register, held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_r     <= '0;
      m_r      <= '0;
      addr_r   <= '0;
      data_r   <= '0;
      result_r <= '0;
    end else if (!mem_stall) begin
      wb_r     <= WB_in;
      m_r      <= M_in;
      addr_r   <= addr_in;
      data_r   <= data_in;
      result_r <= result_in;
    end
  end

  // unacked request cycle counter
  always_ff @(posedge clk) begin
    if (rst)
      tmo_cnt <= '0;
    else if (req_c & ~dmem_ack & ~tmo)
      tmo_cnt <= tmo_cnt + CW'(1);
    else
      tmo_cnt <= '0;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (st_acc)
          state_n = DRAIN;
        else if (rd_req & ~ack_eff)
          state_n = READ;
      end
      DRAIN: begin
        if (ack_eff)
          state_n = st_acc ? DRAIN : IDLE;
      end
      READ: begin
        if (ack_eff)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // bus, stall and write-back outputs
  always_comb begin
    dmem_req   = req_c;
    dmem_we    = (state == DRAIN);
    dmem_addr  = (state == DRAIN) ? wbuf_addr : addr_r;
    dmem_wdata = wbuf_data;
    mem_stall  = 1'b0;
    wb_data    = result_r;
    unique case (1'b1)
      is_st:   mem_stall = wbuf_valid & ~ack_eff;
      is_ld:   mem_stall = ~ld_hit & ~(rd_req & ack_eff);
      default: mem_stall = 1'b0;
    endcase
    if (to_reg) begin
      if (ld_hit)   wb_data = wbuf_data;
      else if (tmo) wb_data = '0;
      else          wb_data = dmem_rdata;
    end
  end

  assign WB         = wb_r;
  assign wbuf_empty = ~wbuf_valid;
  assign bus_err    = tmo;

endmodule

// File: tb/tb_mem_slice.sv
// Directed bench for the MEM stage.
// Bus ack/rdata are driven by hand per cycle.
module tb_mem_slice;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    wb_in;
  logic [2:0]    m_in;
  logic [DW-1:0] addr_in, data_in, result_in;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [6:0]    wb;
  logic [DW-1:0] wb_data;
  logic          mem_stall, wbuf_empty, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_slice #(.DW(DW), .TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .WB_in      (wb_in),
    .M_in       (m_in),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .result_in  (result_in),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .WB         (wb),
    .wb_data    (wb_data),
    .mem_stall  (mem_stall),
    .wbuf_empty (wbuf_empty),
    .bus_err    (bus_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic ex(input logic [2:0]  m,
                    input logic [15:0] a,
                    input logic [15:0] d,
                    input logic [15:0] r,
                    input logic [6:0]  w);
    m_in      = m;
    addr_in   = a;
    data_in   = d;
    result_in = r;
    wb_in     = w;
  endtask

  task automatic nop;
    ex(3'b000, 16'h0, 16'h0, 16'h5A5A, 7'h00);
  endtask

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    ex(3'b000, 16'h0, 16'h0, 16'h0, 7'h00);
    tick; tick; settle;
    check("rst_req",   dmem_req,   0);
    check("rst_we",    dmem_we,    0);
    check("rst_wb",    wb,         0);
    check("rst_wbd",   wb_data,    0);
    check("rst_stall", mem_stall,  0);
    check("rst_empty", wbuf_empty, 1);
    check("rst_berr",  bus_err,    0);
    rst = 1'b0;

    // 1: load, empty buffer, ack after 3 stall cycles
    ex(3'b101, 16'h0010, 16'h0, 16'h7777, 7'h55);
    tick; nop; settle;
    check("t1_req",   dmem_req,  1);
    check("t1_we",    dmem_we,   0);
    check("t1_addr",  dmem_addr, 16'h0010);
    check("t1_wbp",   wb,        7'h55);
    check("t1_stl1",  mem_stall, 1);
    tick; settle;
    check("t1_stl2",  mem_stall, 1);
    tick; settle;
    check("t1_stl3",  mem_stall, 1);
    tick; dmem_ack = 1'b1; dmem_rdata = 16'hBEEF; settle;
    check("t1_ackst", mem_stall, 0);
    check("t1_data",  wb_data,   16'hBEEF);
    tick; dmem_ack = 1'b0; settle;
    check("t1_idle",  dmem_req,  0);
    check("t1_nop",   wb_data,   16'h5A5A);

    // 2: store drains over 2 req cycles
    ex(3'b010, 16'h0040, 16'h1234, 16'h0, 7'h00);
    tick; nop; settle;
    check("t2_nostl", mem_stall, 0);
    check("t2_noreq", dmem_req,  0);
    tick; settle;
    check("t2_req1",  dmem_req,   1);
    check("t2_we1",   dmem_we,    1);
    check("t2_addr1", dmem_addr,  16'h0040);
    check("t2_dat1",  dmem_wdata, 16'h1234);
    check("t2_full",  wbuf_empty, 0);
    check("t2_stl",   mem_stall,  0);
    tick; dmem_ack = 1'b1; settle;
    check("t2_req2",  dmem_req,   1);
    check("t2_addr2", dmem_addr,  16'h0040);
    check("t2_dat2",  dmem_wdata, 16'h1234);
    tick; dmem_ack = 1'b0; settle;
    check("t2_empty", wbuf_empty, 1);
    check("t2_done",  dmem_req,   0);

    // 3: store then load same address forwards
    ex(3'b010, 16'h0040, 16'h1234, 16'h0, 7'h00);
    tick; ex(3'b101, 16'h0040, 16'h0, 16'h9999, 7'h00); settle;
    tick; nop; settle;
    check("t3_data",  wb_data,   16'h1234);
    check("t3_stall", mem_stall, 0);
    check("t3_rdreq", dmem_req & ~dmem_we, 0);
    tick; dmem_ack = 1'b1; settle;
    tick; dmem_ack = 1'b0; settle;
    check("t3_empty", wbuf_empty, 1);

    // 4: store then load other address: drain then read
    ex(3'b010, 16'h0040, 16'hAAAA, 16'h0, 7'h00);
    tick; ex(3'b101, 16'h0050, 16'h0, 16'h0, 7'h00); settle;
    tick; nop; settle;
    check("t4_stl1",  mem_stall, 1);
    check("t4_we1",   dmem_we,   1);
    check("t4_addr1", dmem_addr, 16'h0040);
    tick; dmem_ack = 1'b1; settle;
    check("t4_stl2",  mem_stall, 1);
    check("t4_we2",   dmem_we,   1);
    tick; dmem_ack = 1'b0; settle;
    check("t4_rreq",  dmem_req,  1);
    check("t4_rwe",   dmem_we,   0);
    check("t4_raddr", dmem_addr, 16'h0050);
    check("t4_stl3",  mem_stall, 1);
    tick; dmem_ack = 1'b1; dmem_rdata = 16'hC0DE; settle;
    check("t4_stl4",  mem_stall, 0);
    check("t4_data",  wb_data,   16'hC0DE);
    tick; dmem_ack = 1'b0; settle;
    check("t4_idle",  dmem_req,  0);

    // 5: back-to-back stores, first ack late
    ex(3'b010, 16'h0040, 16'h1111, 16'h0, 7'h00);
    tick; ex(3'b010, 16'h0044, 16'h2222, 16'h0, 7'h00); settle;
    tick; nop; settle;
    check("t5_stl1",  mem_stall,  1);
    check("t5_addr1", dmem_addr,  16'h0040);
    check("t5_dat1",  dmem_wdata, 16'h1111);
    tick; settle;
    check("t5_stl2",  mem_stall,  1);
    check("t5_addr2", dmem_addr,  16'h0040);
    tick; dmem_ack = 1'b1; settle;
    check("t5_acc",   mem_stall,  0);
    tick; dmem_ack = 1'b0; settle;
    check("t5_req",   dmem_req,   1);
    check("t5_we",    dmem_we,    1);
    check("t5_addr3", dmem_addr,  16'h0044);
    check("t5_dat3",  dmem_wdata, 16'h2222);
    check("t5_full",  wbuf_empty, 0);
    dmem_ack = 1'b1; settle;
    tick; dmem_ack = 1'b0; settle;
    check("t5_empty", wbuf_empty, 1);
    check("t5_idle",  dmem_req,   0);

    // 6: read timeout after 4 unacked cycles
    dmem_rdata = 16'hFFFF;
    ex(3'b101, 16'h0060, 16'h0, 16'h3333, 7'h00);
    tick; nop; settle;
    for (int i = 0; i < 4; i++) begin
      check("t6_berr0", bus_err,   0);
      check("t6_stl",   mem_stall, 1);
      tick; settle;
    end
    check("t6_berr",  bus_err,   1);
    check("t6_rel",   mem_stall, 0);
    check("t6_data",  wb_data,   16'h0000);
    tick; settle;
    check("t6_pulse", bus_err,   0);
    check("t6_idle",  dmem_req,  0);
    check("t6_nop",   wb_data,   16'h5A5A);

    // reset during READ drops the request
    ex(3'b101, 16'h0070, 16'h0, 16'h0, 7'h00);
    tick; nop; settle;
    check("t6_rreq1", dmem_req, 1);
    tick; settle;
    check("t6_rreq2", dmem_req, 1);
    rst = 1'b1;
    tick; settle;
    check("t6_rstrq", dmem_req,   0);
    check("t6_rstst", mem_stall,  0);
    check("t6_rstem", wbuf_empty, 1);
    check("t6_rstwd", wb_data,    0);
    rst = 1'b0;
    tick; settle;
    check("t6_after", dmem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
